// File: rtl/toggle_to_pulse.sv
//------------------------------------------------------------------------------
// Module      : toggle_to_pulse
// Description : Receive end of a pulse-to-toggle event link. Synchronises a
//               level toggle, primes after reset, and emits one pulse per
//               accepted transition with pending/overrun flags and a counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module toggle_to_pulse #(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_ena,
    input  logic                   i_toggle,
    input  logic                   i_ack,
    input  logic                   i_clear,
    output logic                   o_pulse,
    output logic                   o_pending,
    output logic                   o_overrun,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic                   o_armed
);

    localparam int                   c_PRIME_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [c_PRIME_W-1:0] c_PRIME_LAST = c_PRIME_W'(SYNC_STAGES);
    localparam logic [c_PRIME_W-1:0] c_PRIME_ONE  = c_PRIME_W'(1);
    localparam logic [COUNT_WIDTH-1:0] c_COUNT_ONE = COUNT_WIDTH'(1);

    localparam logic [0:0] c_ST_PRIME = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;
    logic [c_PRIME_W-1:0]   r_prime_cnt;
    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic                   w_sync_out;
    logic                   w_edge;
    logic                   w_acc;

    logic                   r_pulse;
    logic                   r_pending;
    logic                   r_overrun;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_armed;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_edge     = w_sync_out ^ r_last;

    // Synchroniser and last-value flop track the line in every state so the
    // settled level is already held in r_last when priming finishes.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync <= '0;
            r_last <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_toggle};
            r_last <= w_sync_out;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= c_ST_PRIME;
            r_prime_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_PRIME && r_prime_cnt != c_PRIME_LAST) begin
                r_prime_cnt <= r_prime_cnt + c_PRIME_ONE;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc       = 1'b0;
        case (r_state)
            c_ST_PRIME: begin
                if (r_prime_cnt == c_PRIME_LAST) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                w_acc = w_edge & i_ena;
            end
            default: begin
                w_state_nxt = c_ST_PRIME;
            end
        endcase
    end

    // A new event outranks a same-cycle acknowledge, and a set of the sticky
    // overrun flag outranks a same-cycle clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pulse   <= 1'b0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_count   <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_pulse <= w_acc;
            r_armed <= (r_state == c_ST_RUN);

            if (w_acc) begin
                r_pending <= 1'b1;
            end else if (i_ack) begin
                r_pending <= 1'b0;
            end

            if (w_acc && r_pending && !i_ack) begin
                r_overrun <= 1'b1;
            end else if (i_clear) begin
                r_overrun <= 1'b0;
            end

            if (i_clear) begin
                r_count <= w_acc ? c_COUNT_ONE : '0;
            end else if (w_acc) begin
                r_count <= r_count + c_COUNT_ONE;
            end
        end
    end

    assign o_pulse   = r_pulse;
    assign o_pending = r_pending;
    assign o_overrun = r_overrun;
    assign o_count   = r_count;
    assign o_armed   = r_armed;

endmodule

`default_nettype wire
